temp_bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock.
- Sits between the temperature conversion stage (binary °F/°C result) and the seven-segment driver.
- Produces registered decimal digits with a leading-zero blank mask, so the display stage needs no division logic.
- Start/busy/done handshake; result held stable between conversions.

---
 rtl/temp_bcd_converter.sv | 145 ++++++++++++++
 tb/tb_temp_bcd_converter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/temp_bcd_converter.sv
// -----------------------------------------------------------------------------
// temp_bcd_converter
//
// Converts an unsigned binary temperature reading into packed BCD digits for
// the seven-segment driver. It uses the sequential shift-add-3 (double-dabble)
// method and handles one input bit per clock. A leading-zero blank mask is
// produced with the digits, so the display stage needs no division logic.
//
// Ports
//   clk      in   system clock, rising-edge active
//   rst      in   synchronous reset, active-low
//   bin_in   in   SIZE-bit unsigned value, sampled when start is accepted
//   start    in   conversion request, accepted only when idle
//   busy     out  high while a conversion is in flight
//   done     out  one-cycle pulse in the cycle bcd_out/blank update
//   bcd_out  out  DIGITS packed BCD nibbles, [3:0] = ones
//   blank    out  bit i set when digit i is a leading zero (bit 0 never set)
// -----------------------------------------------------------------------------
module temp_bcd_converter #(
  parameter int SIZE   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE-1:0]       bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t          state_q,   state_d;
  logic [SIZE-1:0] shreg_q,   shreg_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;
  logic [BW-1:0]   bcd_q,     bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;

  logic [BW-1:0]   shift_scr;
  logic [SIZE-1:0] shift_sh;

  // Add 3 to every nibble that is 5 or more, so that the following doubling
  // carries correctly into the next decimal digit. A nibble never exceeds 12.
  function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Walk from the most significant digit down: a digit is blanked only while
  // it and every digit above it are zero. The ones digit is always shown.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] d);
    logic [DIGITS-1:0] m;
    logic              hz;
    m  = '0;
    hz = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hz   = hz & (d[4*i +: 4] == 4'd0);
      m[i] = hz;
    end
    return m;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    blank_d   = blank_q;

    // One double-dabble step: adjust, then shift {scratch, shreg} left by one.
    {shift_scr, shift_sh} = {add3_all(scratch_q), shreg_q} << 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shift_scr;
        shreg_d   = shift_sh;
        cnt_d     = cnt_q + CW'(1);
        // The last input bit has just entered the scratch: publish the result.
        if (cnt_q == LAST) begin
          bcd_d   = shift_scr;
          blank_d = blank_mask(shift_scr);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_temp_bcd_converter.sv
module tb_temp_bcd_converter;

  localparam int SIZE   = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic              clk;
  logic              rst;
  logic [SIZE-1:0]   bin_in;
  logic              start;
  logic              busy;
  logic              done;
  logic [BW-1:0]     bcd_out;
  logic [DIGITS-1:0] blank;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  temp_bcd_converter #(.SIZE(SIZE), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .blank   (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    if (10 ** DIGITS <= 2 ** SIZE - 1) begin
      $display("FAIL param_range DIGITS=%0d too small for SIZE=%0d", DIGITS, SIZE);
      $fatal(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] blank_of(input int v);
    logic [DIGITS-1:0] b;
    b = '0;
    for (int i = 1; i < DIGITS; i++) b[i] = (v < 10 ** i);
    return b;
  endfunction

  bit                m_busy  = 0;
  bit                m_done  = 0;
  int                m_left  = 0;
  int                m_val   = 0;
  logic [BW-1:0]     m_bcd   = '0;
  logic [DIGITS-1:0] m_blank = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0; m_done = 0; m_left = 0; m_val = 0; m_bcd = '0; m_blank = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy  = 0;
          m_done  = 1;
          m_bcd   = to_bcd(m_val);
          m_blank = blank_of(m_val);
        end
      end else if (start) begin
        m_busy = 1;
        m_left = SIZE;
        m_val  = int'(bin_in);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",  32'(busy),    32'(m_busy));
      check("cyc_done",  32'(done),    32'(m_done));
      check("cyc_bcd",   32'(bcd_out), 32'(m_bcd));
      check("cyc_blank", 32'(blank),   32'(m_blank));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(output int n);
    bit found;
    found = 0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        found = 1;
        break;
      end
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  task automatic run_conv(input int val, input logic [BW-1:0] exp_bcd,
                          input logic [DIGITS-1:0] exp_blank);
    int n;
    @(posedge clk); #1;
    bin_in = SIZE'(val);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_done(n);
    check("latency_edges", 32'(n), 32'(SIZE));
    check("lit_bcd",   32'(bcd_out), 32'(exp_bcd));
    check("lit_blank", 32'(blank),   32'(exp_blank));
  endtask

  int                vals   [5] = '{212, 0, 32, 255, 100};
  logic [BW-1:0]     ebcd   [5] = '{12'h212, 12'h000, 12'h032, 12'h255, 12'h100};
  logic [DIGITS-1:0] eblank [5] = '{3'b000, 3'b110, 3'b100, 3'b000, 3'b000};

  initial begin
    int n;
    bit seen;
    rst    = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    check("rst_bcd",   32'(bcd_out), 32'd0);
    check("rst_blank", 32'(blank),   32'd0);

    for (int i = 0; i < 5; i++) run_conv(vals[i], ebcd[i], eblank[i]);

    // start re-pulsed with a new value while busy is ignored
    @(posedge clk); #1;
    bin_in = 8'd37;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    @(posedge clk); #1;
    bin_in = 8'd99;
    start  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(n);
    check("ignore_latency", 32'(n + 4), 32'(SIZE));
    check("ignore_bcd",     32'(bcd_out), 32'h037);
    check("ignore_blank",   32'(blank),   32'(3'b100));
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("ignore_idle", 32'(busy), 32'd0);

    // start held high: back-to-back conversions
    bin_in = 8'd100;
    start  = 1'b1;
    @(posedge clk); #1;
    bin_in = 8'd37;
    wait_done(n);
    check("b2b_first_bcd", 32'(bcd_out), 32'h100);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("b2b_spacing",    32'(n + 1), 32'(SIZE + 1));
    check("b2b_second_bcd", 32'(bcd_out), 32'h037);

    // reset during the fourth shift step aborts without a done pulse
    @(posedge clk); #1;
    bin_in = 8'd200;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_busy",  32'(busy),    32'd0);
    check("abort_done",  32'(done),    32'd0);
    check("abort_bcd",   32'(bcd_out), 32'd0);
    check("abort_blank", 32'(blank),   32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_conv(77, 12'h077, 3'b100);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
